// File: rtl/ddr_timing_monitor_if.sv
// DDR4 command bus as seen between controller and DRAM.
// The controller side drives it; the timing monitor only observes it.
interface ddr_timing_monitor_if #(
   parameter int BG_W = 2,
   parameter int BA_W = 2
) ();
   logic            cs_n;
   logic            act_n;
   logic            ras_n_a16;
   logic            cas_n_a15;
   logic            we_n_a14;
   logic            a10;
   logic [BG_W-1:0] bg_addr;
   logic [BA_W-1:0] ba_addr;

   modport master (
      output cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14, a10, bg_addr, ba_addr
   );

   modport slave (
      input  cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14, a10, bg_addr, ba_addr
   );
endinterface

// File: rtl/ddr_timing_monitor.sv
// DDR4 command-bus timing monitor.
// Tracks per-bank open/closed state and per-bank/global spacing timers. It
// flags violations as registered one-cycle pulses, sticky flags, a saturating
// count of violating cycles and last-offender information.
// Timers load T-1 when the first command of a pair issues and count down to 0.
// A later command is therefore legal exactly when its timer already reads 0.
module ddr_timing_monitor #(
   parameter int BG_W    = 2,
   parameter int BA_W    = 2,
   parameter int T_RCD   = 12,
   parameter int T_RP    = 12,
   parameter int T_RAS   = 28,
   parameter int T_CCD   = 4,
   parameter int T_RD2WR = 9,
   parameter int T_WR2RD = 20,
   parameter int T_RTP   = 6,
   parameter int T_WTP   = 26,
   parameter int T_REFI  = 6240,
   parameter int CNT_W   = 16
) (
   input  logic                                clock_t,
   input  logic                                reset_n,
   input  logic                                en,
   input  logic                                clr,
   ddr_timing_monitor_if.slave                 cmd_bus,
   output logic [8:0]                          viol_pulse,
   output logic [8:0]                          viol_sticky,
   output logic [CNT_W-1:0]                    viol_count,
   output logic [3:0]                          last_code,
   output logic [BG_W+BA_W-1:0]                last_bank,
   output logic [(2**(BG_W+BA_W))-1:0]         bank_open
);

   localparam int BK_W = BG_W + BA_W;
   localparam int NB   = 2**BK_W;

   function automatic int max2(int a, int b);
      return (a > b) ? a : b;
   endfunction

   localparam int T_MAX = max2(max2(max2(T_RCD, T_RP), max2(T_RAS, T_CCD)),
                               max2(max2(T_RD2WR, T_WR2RD), max2(T_RTP, T_WTP)));
   localparam int TMR_W = $clog2(T_MAX + 1);
   localparam int REF_W = $clog2(T_REFI + 1);

   typedef logic [TMR_W-1:0] tmr_t;

   typedef enum logic [2:0] {
      CMD_NONE,
      CMD_ACT,
      CMD_REF,
      CMD_PRE,
      CMD_RD,
      CMD_WR
   } cmd_e;

   localparam tmr_t LD_RCD   = tmr_t'(T_RCD - 1);
   localparam tmr_t LD_RP    = tmr_t'(T_RP - 1);
   localparam tmr_t LD_RAS   = tmr_t'(T_RAS - 1);
   localparam tmr_t LD_CCD   = tmr_t'(T_CCD - 1);
   localparam tmr_t LD_RD2WR = tmr_t'(T_RD2WR - 1);
   localparam tmr_t LD_WR2RD = tmr_t'(T_WR2RD - 1);
   localparam tmr_t LD_RTP   = tmr_t'(T_RTP - 1);
   localparam tmr_t LD_WTP   = tmr_t'(T_WTP - 1);

   localparam logic [REF_W-1:0] REF_MAX  = REF_W'(T_REFI);
   localparam logic [REF_W-1:0] REF_LAST = REF_W'(T_REFI - 1);

   function automatic tmr_t dec(tmr_t t);
      return (t == '0) ? '0 : t - tmr_t'(1);
   endfunction

   // Decoded command and its target bank
   cmd_e            cmd;
   logic [BK_W-1:0] bank;

   // Bank state and timers
   logic [NB-1:0]   open_q, open_d;
   tmr_t            rcd_q [NB], rcd_d [NB];
   tmr_t            rp_q  [NB], rp_d  [NB];
   tmr_t            ras_q [NB], ras_d [NB];
   tmr_t            rtp_q [NB], rtp_d [NB];
   tmr_t            wtp_q [NB], wtp_d [NB];
   tmr_t            ccd_rd_q, ccd_rd_d;
   tmr_t            ccd_wr_q, ccd_wr_d;
   tmr_t            rd2wr_q, rd2wr_d;
   tmr_t            wr2rd_q, wr2rd_d;
   logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;

   // Violations detected for the command on the bus this cycle
   logic [8:0]      viol;
   logic [BK_W-1:0] viol_bank;
   logic [3:0]      low_code;

   // Reporting registers
   logic [8:0]      pulse_q, pulse_d;
   logic [8:0]      sticky_q, sticky_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [3:0]      code_q, code_d;
   logic [BK_W-1:0] lbank_q, lbank_d;

   // Decode the bus; deselect, disabled monitor and MRS/ZQ/NOP all mean no command
   always_comb begin
      // NOTE: every always_comb output is given a default first so no path can infer a latch.
      cmd  = CMD_NONE;
      bank = {cmd_bus.bg_addr, cmd_bus.ba_addr};
      if (en && !cmd_bus.cs_n) begin
         if (!cmd_bus.act_n) begin
            cmd = CMD_ACT;
         end else begin
            case ({cmd_bus.ras_n_a16, cmd_bus.cas_n_a15, cmd_bus.we_n_a14})
               3'b001:  cmd = CMD_REF;
               3'b010:  cmd = CMD_PRE;
               3'b101:  cmd = CMD_RD;
               3'b100:  cmd = CMD_WR;
               default: cmd = CMD_NONE;
            endcase
         end
      end
   end

   // Check the command against pre-command state, then apply its effect on banks and timers
   always_comb begin
      open_d    = open_q;
      ccd_rd_d  = dec(ccd_rd_q);
      ccd_wr_d  = dec(ccd_wr_q);
      rd2wr_d   = dec(rd2wr_q);
      wr2rd_d   = dec(wr2rd_q);
      for (int i = 0; i < NB; i++) begin
         rcd_d[i] = dec(rcd_q[i]);
         rp_d[i]  = dec(rp_q[i]);
         ras_d[i] = dec(ras_q[i]);
         rtp_d[i] = dec(rtp_q[i]);
         wtp_d[i] = dec(wtp_q[i]);
      end
      ref_cnt_d = ref_cnt_q;
      viol      = '0;
      viol_bank = bank;

      case (cmd)
         CMD_ACT: begin
            viol[0]      = open_q[bank];
            viol[1]      = (rp_q[bank] != '0);
            open_d[bank] = 1'b1;
            rcd_d[bank]  = LD_RCD;
            ras_d[bank]  = LD_RAS;
         end
         CMD_RD: begin
            viol[2]     = (rcd_q[bank] != '0);
            viol[3]     = !open_q[bank];
            viol[4]     = (ccd_rd_q != '0);
            viol[5]     = (wr2rd_q != '0);
            ccd_rd_d    = LD_CCD;
            rd2wr_d     = LD_RD2WR;
            rtp_d[bank] = LD_RTP;
         end
         CMD_WR: begin
            viol[2]     = (rcd_q[bank] != '0);
            viol[3]     = !open_q[bank];
            viol[4]     = (ccd_wr_q != '0);
            viol[5]     = (rd2wr_q != '0);
            ccd_wr_d    = LD_CCD;
            wr2rd_d     = LD_WR2RD;
            wtp_d[bank] = LD_WTP;
         end
         CMD_PRE: begin
            // Walk downwards so the lowest violating bank is the one reported
            for (int i = NB - 1; i >= 0; i--) begin
               if (open_q[i] && (cmd_bus.a10 || (bank == BK_W'(i)))) begin
                  if (ras_q[i] != '0) begin
                     viol[6]   = 1'b1;
                     viol_bank = BK_W'(i);
                  end
                  if ((rtp_q[i] != '0) || (wtp_q[i] != '0)) begin
                     viol[7]   = 1'b1;
                     viol_bank = BK_W'(i);
                  end
                  open_d[i] = 1'b0;
                  rp_d[i]   = LD_RP;
               end
            end
         end
         default: ;
      endcase

      // Refresh interval counts enabled cycles only and saturates so it fires once
      if (en) begin
         if (cmd == CMD_REF) begin
            ref_cnt_d = '0;
         end else if (ref_cnt_q != REF_MAX) begin
            ref_cnt_d = ref_cnt_q + 1'b1;
            viol[8]   = (ref_cnt_q == REF_LAST);
         end
      end
   end

   // Fold this cycle's violations into the reporting registers; clr wins
   always_comb begin
      low_code = '0;
      for (int k = 8; k >= 0; k--) begin
         if (viol[k]) low_code = 4'(k);
      end
      pulse_d  = viol;
      sticky_d = sticky_q | viol;
      count_d  = count_q;
      code_d   = code_q;
      lbank_d  = lbank_q;
      if (|viol) begin
         if (count_q != '1) count_d = count_q + 1'b1;
         code_d = low_code;
         // A refresh-only violation has no offending command, so the bank is kept
         if (|viol[7:0]) lbank_d = viol_bank;
      end
      if (clr) begin
         sticky_d = '0;
         count_d  = '0;
         code_d   = '0;
         lbank_d  = '0;
      end
   end

   // State register with synchronous active-low reset
   always_ff @(posedge clock_t) begin
      // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
      if (!reset_n) begin
         open_q    <= '0;
         ccd_rd_q  <= '0;
         ccd_wr_q  <= '0;
         rd2wr_q   <= '0;
         wr2rd_q   <= '0;
         // NOTE: the timer arrays are flops rather than a RAM, so they are reset like any register.
         for (int i = 0; i < NB; i++) begin
            rcd_q[i] <= '0;
            rp_q[i]  <= '0;
            ras_q[i] <= '0;
            rtp_q[i] <= '0;
            wtp_q[i] <= '0;
         end
         ref_cnt_q <= '0;
         pulse_q   <= '0;
         sticky_q  <= '0;
         count_q   <= '0;
         code_q    <= '0;
         lbank_q   <= '0;
      end else begin
         open_q    <= open_d;
         ccd_rd_q  <= ccd_rd_d;
         ccd_wr_q  <= ccd_wr_d;
         rd2wr_q   <= rd2wr_d;
         wr2rd_q   <= wr2rd_d;
         for (int i = 0; i < NB; i++) begin
            rcd_q[i] <= rcd_d[i];
            rp_q[i]  <= rp_d[i];
            ras_q[i] <= ras_d[i];
            rtp_q[i] <= rtp_d[i];
            wtp_q[i] <= wtp_d[i];
         end
         ref_cnt_q <= ref_cnt_d;
         pulse_q   <= pulse_d;
         sticky_q  <= sticky_d;
         count_q   <= count_d;
         code_q    <= code_d;
         lbank_q   <= lbank_d;
      end
   end

   assign viol_pulse  = pulse_q;
   assign viol_sticky = sticky_q;
   assign viol_count  = count_q;
   assign last_code   = code_q;
   assign last_bank   = lbank_q;
   assign bank_open   = open_q;

endmodule

// File: tb/tb_ddr_timing_monitor.sv
// Testbench for ddr_timing_monitor: directed table, refresh sequence and
// randomized traffic, all compared against a timestamp-based reference model.
module tb_ddr_timing_monitor;

   localparam int NB      = 16;
   localparam int T_RCD   = 12;
   localparam int T_RP    = 12;
   localparam int T_RAS   = 28;
   localparam int T_CCD   = 4;
   localparam int T_RD2WR = 9;
   localparam int T_WR2RD = 20;
   localparam int T_RTP   = 6;
   localparam int T_WTP   = 26;
   localparam int T_REFI  = 6240;
   localparam int FAR     = -1000000;

   typedef enum int {C_DESEL, C_NOP, C_MRS, C_ZQ, C_ACT, C_REF, C_PRE, C_RD, C_WR} cmd_e;

   typedef struct {
      bit          rst;
      int          gap;
      cmd_e        cmd;
      int          bank;
      bit          a10;
      bit          en;
      bit          clr;
      logic [8:0]  exp_pulse;
      int          exp_count;
      logic [15:0] exp_open;
   } step_t;

   logic        clock_t = 1'b0;
   logic        reset_n = 1'b0;
   logic        en      = 1'b0;
   logic        clr     = 1'b0;
   logic [8:0]  viol_pulse, viol_sticky, pulse2, sticky2;
   logic [15:0] viol_count;
   logic [1:0]  count2;
   logic [3:0]  last_code, last_bank, code2, bank2;
   logic [15:0] bank_open, open2;

   int n_checks = 0;
   int n_err    = 0;
   int now      = 0;

   // Reference model state: timestamps of the last command of each kind
   int         m_last_act [NB];
   int         m_last_pre [NB];
   int         m_last_rdb [NB];
   int         m_last_wrb [NB];
   bit         m_open     [NB];
   int         m_last_rd, m_last_wr;
   int         m_ref_since;
   bit         m_ref_fired;
   logic [8:0] m_pulse, m_sticky;
   int         m_count, m_count2;
   logic [3:0] m_code, m_bank;

   ddr_timing_monitor_if #(.BG_W(2), .BA_W(2)) bus ();

   ddr_timing_monitor dut (
      .clock_t     (clock_t),
      .reset_n     (reset_n),
      .en          (en),
      .clr         (clr),
      .cmd_bus     (bus.slave),
      .viol_pulse  (viol_pulse),
      .viol_sticky (viol_sticky),
      .viol_count  (viol_count),
      .last_code   (last_code),
      .last_bank   (last_bank),
      .bank_open   (bank_open)
   );

   // Narrow counter copy so count saturation is reachable
   ddr_timing_monitor #(.CNT_W(2)) dut_sat (
      .clock_t     (clock_t),
      .reset_n     (reset_n),
      .en          (en),
      .clr         (clr),
      .cmd_bus     (bus.slave),
      .viol_pulse  (pulse2),
      .viol_sticky (sticky2),
      .viol_count  (count2),
      .last_code   (code2),
      .last_bank   (bank2),
      .bank_open   (open2)
   );

   always #5 clock_t = ~clock_t;

   task automatic check(string nm, logic [31:0] got, logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_err++;
         if (n_err <= 40)
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, now, got, want);
      end
   endtask

   task automatic model_reset();
      for (int b = 0; b < NB; b++) begin
         m_last_act[b] = FAR;
         m_last_pre[b] = FAR;
         m_last_rdb[b] = FAR;
         m_last_wrb[b] = FAR;
         m_open[b]     = 1'b0;
      end
      m_last_rd   = FAR;
      m_last_wr   = FAR;
      m_ref_since = 0;
      m_ref_fired = 1'b0;
      m_pulse     = '0;
      m_sticky    = '0;
      m_count     = 0;
      m_count2    = 0;
      m_code      = '0;
      m_bank      = '0;
      now         = 0;
   endtask

   task automatic model_step(cmd_e c, int bank, bit a10, bit en_i, bit clr_i);
      logic [8:0] v;
      int         vb;
      bit         found;
      bit         r6, r7;
      v     = '0;
      vb    = bank;
      found = 1'b0;
      if (en_i) begin
         case (c)
            C_ACT: begin
               v[0] = m_open[bank];
               v[1] = (now - m_last_pre[bank]) < T_RP;
               m_open[bank]     = 1'b1;
               m_last_act[bank] = now;
            end
            C_RD: begin
               v[2] = (now - m_last_act[bank]) < T_RCD;
               v[3] = !m_open[bank];
               v[4] = (now - m_last_rd) < T_CCD;
               v[5] = (now - m_last_wr) < T_WR2RD;
               m_last_rd        = now;
               m_last_rdb[bank] = now;
            end
            C_WR: begin
               v[2] = (now - m_last_act[bank]) < T_RCD;
               v[3] = !m_open[bank];
               v[4] = (now - m_last_wr) < T_CCD;
               v[5] = (now - m_last_rd) < T_RD2WR;
               m_last_wr        = now;
               m_last_wrb[bank] = now;
            end
            C_PRE: begin
               for (int b = 0; b < NB; b++) begin
                  if (m_open[b] && (a10 || b == bank)) begin
                     r6 = (now - m_last_act[b]) < T_RAS;
                     r7 = ((now - m_last_rdb[b]) < T_RTP) || ((now - m_last_wrb[b]) < T_WTP);
                     if (r6) v[6] = 1'b1;
                     if (r7) v[7] = 1'b1;
                     if ((r6 || r7) && !found) begin
                        vb    = b;
                        found = 1'b1;
                     end
                     m_open[b]     = 1'b0;
                     m_last_pre[b] = now;
                  end
               end
            end
            default: ;
         endcase
         if (c == C_REF) begin
            m_ref_since = 0;
            m_ref_fired = 1'b0;
         end else begin
            m_ref_since++;
            if (m_ref_since >= T_REFI && !m_ref_fired) begin
               v[8]        = 1'b1;
               m_ref_fired = 1'b1;
            end
         end
      end
      m_pulse = v;
      if (clr_i) begin
         m_sticky = '0;
         m_count  = 0;
         m_count2 = 0;
         m_code   = '0;
         m_bank   = '0;
      end else if (v != '0) begin
         m_sticky = m_sticky | v;
         m_count  = (m_count == 65535) ? 65535 : m_count + 1;
         m_count2 = (m_count2 == 3) ? 3 : m_count2 + 1;
         for (int k = 8; k >= 0; k--) if (v[k]) m_code = 4'(k);
         if (v[7:0] != '0) m_bank = 4'(vb);
      end
   endtask

   task automatic compare_all();
      logic [15:0] mo;
      for (int b = 0; b < NB; b++) mo[b] = m_open[b];
      check("pulse",     viol_pulse,  m_pulse);
      check("sticky",    viol_sticky, m_sticky);
      check("count",     viol_count,  m_count);
      check("last_code", last_code,   m_code);
      check("last_bank", last_bank,   m_bank);
      check("bank_open", bank_open,   mo);
      check("sat_pulse", pulse2,      m_pulse);
      check("sat_count", count2,      m_count2);
      check("sat_code",  code2,       m_code);
      check("sat_bank",  bank2,       m_bank);
      check("sat_open",  open2,       mo);
      check("sat_stky",  sticky2,     m_sticky);
   endtask

   task automatic drive(cmd_e c, int bank, bit a10);
      logic [3:0] b;
      b            = 4'(bank);
      bus.bg_addr  = b[3:2];
      bus.ba_addr  = b[1:0];
      bus.a10      = a10;
      bus.cs_n     = 1'b0;
      bus.act_n    = 1'b1;
      case (c)
         // Deselect carries a PRE pattern so chip-select gating is exercised
         C_DESEL: begin bus.cs_n = 1'b1; {bus.ras_n_a16, bus.cas_n_a15, bus.we_n_a14} = 3'b010; end
         C_NOP:   {bus.ras_n_a16, bus.cas_n_a15, bus.we_n_a14} = 3'b111;
         C_MRS:   {bus.ras_n_a16, bus.cas_n_a15, bus.we_n_a14} = 3'b000;
         C_ZQ:    {bus.ras_n_a16, bus.cas_n_a15, bus.we_n_a14} = 3'b110;
         C_ACT:   begin bus.act_n = 1'b0; {bus.ras_n_a16, bus.cas_n_a15, bus.we_n_a14} = 3'($urandom); end
         C_REF:   {bus.ras_n_a16, bus.cas_n_a15, bus.we_n_a14} = 3'b001;
         C_PRE:   {bus.ras_n_a16, bus.cas_n_a15, bus.we_n_a14} = 3'b010;
         C_RD:    {bus.ras_n_a16, bus.cas_n_a15, bus.we_n_a14} = 3'b101;
         default: {bus.ras_n_a16, bus.cas_n_a15, bus.we_n_a14} = 3'b100;
      endcase
   endtask

   task automatic cycle(cmd_e c, int bank, bit a10, bit en_i, bit clr_i);
      drive(c, bank, a10);
      en  = en_i;
      clr = clr_i;
      model_step(c, bank, a10, en_i, clr_i);
      @(posedge clock_t);
      #1;
      now++;
      compare_all();
   endtask

   task automatic reset_dut();
      reset_n = 1'b0;
      en      = 1'b1;
      clr     = 1'b0;
      drive(C_DESEL, 0, 1'b0);
      repeat (2) @(posedge clock_t);
      #1;
      model_reset();
      check("rst_pulse",  viol_pulse,  9'h000);
      check("rst_sticky", viol_sticky, 9'h000);
      check("rst_count",  viol_count,  16'h0000);
      check("rst_code",   last_code,   4'h0);
      check("rst_bank",   last_bank,   4'h0);
      check("rst_open",   bank_open,   16'h0000);
      reset_n = 1'b1;
   endtask

   function automatic step_t mk(bit rst, int gap, cmd_e c, int bank, bit a10, bit en_i,
                                bit clr_i, logic [8:0] p, int cnt, logic [15:0] op);
      step_t s;
      s.rst = rst; s.gap = gap; s.cmd = c; s.bank = bank; s.a10 = a10;
      s.en = en_i; s.clr = clr_i; s.exp_pulse = p; s.exp_count = cnt; s.exp_open = op;
      return s;
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL watchdog cycle=%0d got=timeout expected=finish", now);
      $fatal(1, "watchdog expired");
   end

   initial begin
      step_t tbl [$];
      cmd_e  c;
      int    r, bk;

      // Legal flow on bank 6 (bg=1, ba=2)
      tbl.push_back(mk(1,  0, C_ACT, 6, 0, 1, 0, 9'h000, 0, 16'h0040));
      tbl.push_back(mk(0, 11, C_RD,  6, 0, 1, 0, 9'h000, 0, 16'h0040));
      tbl.push_back(mk(0,  3, C_RD,  6, 0, 1, 0, 9'h000, 0, 16'h0040));
      tbl.push_back(mk(0,  8, C_WR,  6, 0, 1, 0, 9'h000, 0, 16'h0040));
      tbl.push_back(mk(0, 25, C_PRE, 6, 0, 1, 0, 9'h000, 0, 16'h0000));
      tbl.push_back(mk(0, 11, C_ACT, 6, 0, 1, 0, 9'h000, 0, 16'h0040));
      // RD one cycle early after ACT
      tbl.push_back(mk(1,  0, C_ACT, 6, 0, 1, 0, 9'h000, 0, 16'h0040));
      tbl.push_back(mk(0, 10, C_RD,  6, 0, 1, 0, 9'h004, 1, 16'h0040));
      // Read/write turnaround in both directions
      tbl.push_back(mk(1,  0, C_ACT, 6, 0, 1, 0, 9'h000, 0, 16'h0040));
      tbl.push_back(mk(0, 11, C_RD,  6, 0, 1, 0, 9'h000, 0, 16'h0040));
      tbl.push_back(mk(0,  7, C_WR,  6, 0, 1, 0, 9'h020, 1, 16'h0040));
      tbl.push_back(mk(0, 19, C_WR,  6, 0, 1, 0, 9'h000, 1, 16'h0040));
      tbl.push_back(mk(0, 18, C_RD,  6, 0, 1, 0, 9'h020, 2, 16'h0040));
      // Precharge-all too early, then ACT inside tRP
      tbl.push_back(mk(1,  0, C_ACT, 0, 0, 1, 0, 9'h000, 0, 16'h0001));
      tbl.push_back(mk(0,  1, C_ACT, 3, 0, 1, 0, 9'h000, 0, 16'h0009));
      tbl.push_back(mk(0, 17, C_PRE, 5, 1, 1, 0, 9'h040, 1, 16'h0000));
      tbl.push_back(mk(0,  9, C_ACT, 3, 0, 1, 0, 9'h002, 2, 16'h0008));
      // clr in the same cycle as a violation, then RD to a closed bank
      tbl.push_back(mk(1,  0, C_ACT, 6, 0, 1, 0, 9'h000, 0, 16'h0040));
      tbl.push_back(mk(0,  9, C_RD,  6, 0, 1, 1, 9'h004, 0, 16'h0040));
      tbl.push_back(mk(0,  0, C_RD,  5, 0, 1, 0, 9'h018, 1, 16'h0040));
      // PRE to a closed bank is legal and leaves tRP unloaded; double ACT
      tbl.push_back(mk(1,  0, C_PRE, 2, 0, 1, 0, 9'h000, 0, 16'h0000));
      tbl.push_back(mk(0,  0, C_ACT, 2, 0, 1, 0, 9'h000, 0, 16'h0004));
      tbl.push_back(mk(0,  0, C_ACT, 2, 0, 1, 0, 9'h001, 1, 16'h0004));
      // Disabled monitor ignores commands
      tbl.push_back(mk(1,  0, C_ACT, 1, 0, 0, 0, 9'h000, 0, 16'h0000));
      tbl.push_back(mk(0,  0, C_ACT, 1, 0, 1, 0, 9'h000, 0, 16'h0002));
      tbl.push_back(mk(0,  0, C_ACT, 4, 0, 1, 0, 9'h000, 0, 16'h0012));
      // Reset mid-operation discards bank state and timers
      tbl.push_back(mk(1,  0, C_ACT, 4, 0, 1, 0, 9'h000, 0, 16'h0010));
      // MRS, ZQ and NOP decode as no command
      tbl.push_back(mk(1,  0, C_ACT, 7, 0, 1, 0, 9'h000, 0, 16'h0080));
      tbl.push_back(mk(0,  0, C_MRS, 7, 0, 1, 0, 9'h000, 0, 16'h0080));
      tbl.push_back(mk(0,  0, C_ZQ,  7, 0, 1, 0, 9'h000, 0, 16'h0080));
      tbl.push_back(mk(0,  0, C_NOP, 7, 0, 1, 0, 9'h000, 0, 16'h0080));
      // PRE inside write recovery
      tbl.push_back(mk(1,  0, C_ACT, 6, 0, 1, 0, 9'h000, 0, 16'h0040));
      tbl.push_back(mk(0, 11, C_WR,  6, 0, 1, 0, 9'h000, 0, 16'h0040));
      tbl.push_back(mk(0, 17, C_PRE, 6, 0, 1, 0, 9'h080, 1, 16'h0000));

      foreach (tbl[k]) begin
         if (tbl[k].rst) reset_dut();
         repeat (tbl[k].gap) cycle(C_DESEL, 0, 1'b0, 1'b1, 1'b0);
         cycle(tbl[k].cmd, tbl[k].bank, tbl[k].a10, tbl[k].en, tbl[k].clr);
         check($sformatf("tbl%0d_pulse", k), viol_pulse, tbl[k].exp_pulse);
         check($sformatf("tbl%0d_count", k), viol_count, tbl[k].exp_count);
         check($sformatf("tbl%0d_open",  k), bank_open,  tbl[k].exp_open);
      end

      // Refresh overdue fires exactly once, and not again within tREFI of a REF
      reset_dut();
      repeat (T_REFI - 1) cycle(C_DESEL, 0, 1'b0, 1'b1, 1'b0);
      check("ref_early", viol_pulse, 9'h000);
      cycle(C_DESEL, 0, 1'b0, 1'b1, 1'b0);
      check("ref_fire", viol_pulse, 9'h100);
      check("ref_code", last_code, 4'h8);
      repeat (5) begin
         cycle(C_DESEL, 0, 1'b0, 1'b1, 1'b0);
         check("ref_once", viol_pulse, 9'h000);
      end
      cycle(C_REF, 0, 1'b0, 1'b1, 1'b0);
      repeat (T_REFI - 1) cycle(C_DESEL, 0, 1'b0, 1'b1, 1'b0);
      check("ref_quiet_pulse", viol_pulse, 9'h000);
      check("ref_quiet_count", viol_count, 16'h0001);

      // Randomized traffic against the reference model
      reset_dut();
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 499) == 0) reset_dut();
         r = $urandom_range(0, 99);
         if      (r < 30) c = C_DESEL;
         else if (r < 34) c = C_NOP;
         else if (r < 36) c = C_MRS;
         else if (r < 38) c = C_ZQ;
         else if (r < 56) c = C_ACT;
         else if (r < 68) c = C_PRE;
         else if (r < 82) c = C_RD;
         else if (r < 95) c = C_WR;
         else             c = C_REF;
         bk = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
         cycle(c, bk, $urandom_range(0, 3) == 0, $urandom_range(0, 15) != 0,
               $urandom_range(0, 40) == 0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/ddr_timing_monitor.md
Name: ddr_timing_monitor

Overview:
Synthesizable, parametrised DDR4 command-bus timing monitor. It generalises the bench-only concurrent-assertion checker to NUM_BG×NUM_BA banks, with per-bank open/closed state and per-bank timers. It snoops the controller-to-DRAM command bus beside the interface and reports violations as registered pulses, sticky flags, a saturating count and last-offender info. It can run in simulation or on silicon for debug.

Parameters:
BG_W, 2, bank-group address width; NUM_BG = 2**BG_W
BA_W, 2, bank address width; NUM_BA = 2**BA_W; NB = NUM_BG*NUM_BA
T_RCD, 12, min cycles ACT to RD/WR, same bank
T_RP, 12, min cycles PRE to ACT, same bank
T_RAS, 28, min cycles ACT to PRE, same bank
T_CCD, 4, min cycles RD-RD or WR-WR, any bank
T_RD2WR, 9, min cycles RD to WR, any bank
T_WR2RD, 20, min cycles WR to RD, any bank (CWL+4+tWTR)
T_RTP, 6, min cycles RD to PRE, same bank
T_WTP, 26, min cycles WR to PRE, same bank (CWL+4+tWR)
T_REFI, 6240, max cycles between REF commands
CNT_W, 16, violation counter width

Ports:
clock_t  in  1  DDR clock; all logic on posedge
reset_n  in  1  synchronous active-low reset
en  in  1  monitor enable
clr  in  1  clears viol_sticky, viol_count, last_code, last_bank
cs_n  in  1  chip select
act_n  in  1  activate
ras_n_a16  in  1  RAS / A16
cas_n_a15  in  1  CAS / A15
we_n_a14  in  1  WE / A14
a10  in  1  A10; PRE with a10=1 is precharge-all
bg_addr  in  BG_W  bank group
ba_addr  in  BA_W  bank
viol_pulse  out  9  one-cycle per-code violation strobe
viol_sticky  out  9  OR-accumulated viol_pulse
viol_count  out  CNT_W  cycles with ≥1 violation, saturating
last_code  out  4  lowest code of most recent violating cycle
last_bank  out  BG_W+BA_W  {bg,ba} of most recent violating command
bank_open  out  NB  per-bank ACTIVE state, index {bg,ba}

Behaviour:
- Reset (reset_n=0 at posedge): all outputs 0; all banks CLOSED; all timers "satisfied"; refresh counter 0.
- Decode, cs_n=0 only; cs_n=1 means no command.
  - act_n=0: ACT.
  - act_n=1, {ras,cas,we}: 001 REF, 010 PRE, 101 RD, 100 WR.
  - 000 MRS, 110 ZQ, 111 NOP: ignored.
- Spacing rule: command B at cycle m after command A at cycle n is legal iff m-n ≥ T. Timers load on A and decrement saturating at 0. Check uses pre-command state. The command then takes effect regardless of violation.
- Violation codes (bit index):
  - 0: ACT to OPEN bank.
  - 1: ACT <T_RP after PRE to that bank.
  - 2: RD/WR <T_RCD after ACT.
  - 3: RD/WR to CLOSED bank.
  - 4: same-type CAS <T_CCD after previous CAS.
  - 5: RD→WR <T_RD2WR, or WR→RD <T_WR2RD.
  - 6: PRE <T_RAS after ACT.
  - 7: PRE <T_RTP after last RD or <T_WTP after last WR to bank.
  - 8: refresh overdue.
- PRE to a CLOSED bank: legal, no timer reload. Precharge-all applies checks 6/7 to every OPEN bank; last_bank = lowest violating bank index. Precharge-all closes all banks and loads T_RP on every bank that was open.
- Bank state: ACT sets OPEN; PRE clears it. bank_open is registered and updates one cycle after the command.
- Refresh: counter increments each enabled cycle and clears on REF. When it reaches T_REFI, code 8 pulses once. It does not re-fire until the next REF.
- Outputs registered: viol_pulse asserts the cycle after the offending command and lasts exactly 1 cycle. Several codes may assert in the same cycle. viol_count increments by 1 per violating cycle and holds at all-ones.
- clr: clears sticky, count and last_* the next cycle; it has priority over same-cycle updates. It does not affect bank state or timers.
- en=0: commands are not decoded and no pulses fire. Timers keep decrementing; the refresh counter holds. Bank state is frozen.
- Reset asserted mid-operation: same as power-up reset; any in-flight timers are discarded.

Test Plan:
- Legal flow, bg=1 ba=2, defaults: ACT@0, RD@12, RD@16, WR@25, PRE@51, ACT@63 → viol_pulse stays 0, viol_count=0. bank_open[6] is 1 from cycle 1 to cycle 51, then 0 from cycle 52.
- ACT@0, RD@11 → viol_pulse[2]=1 at cycle 12. last_code=2, last_bank=6, viol_count=1.
- ACT@0, RD@12, WR@20 (8<9) → bit5 at cycle 21. WR@40, RD@59 → bit5 again at cycle 60. viol_sticky=0x020, viol_count=2.
- ACT bank0@0, ACT bank3@2, PRE-all (a10=1)@20 → bit6 at cycle 21, last_bank=0, bank_open=0. ACT bank3@30 → bit1 at cycle 31.
- No REF for 6240 enabled cycles → single bit8 pulse. REF, then 6239 further cycles → no pulse.
- Violation at cycle 10 and clr at cycle 10 → viol_count=0 and sticky=0 at cycle 11. viol_pulse still strobes. A second RD to a closed bank → count=1, last_code=3.
